// File: rtl/mem_stage_vlat.sv
// rtl/mem_stage_vlat.sv - MEM pipeline stage for a variable-latency data SRAM
//
// Purpose:
//   Holds one instruction between EX and WB.  A memory instruction waits
//   until its data response arrives.  The response is bypassed straight to
//   WB when WB is ready.  Otherwise it is parked in a one-entry buffer.
//   Responses that belong to flushed instructions are counted and dropped.
//   Load data is extracted for lb/lbu/lh/lhu/lw/lwl/lwr.  Per-byte write
//   strobes and a forward/block bus are produced for ID.
//
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   ms_flush                         flush from WB (exception / eret)
//   ws_allowin / ms_allowin          pipeline handshake toward WB / from EX
//   es_to_ms_valid, es_*             instruction fields presented by EX
//   data_sram_data_ok/_rdata         in-order data SRAM response
//   ms_to_ws_valid, ms_gr_strb,
//   ms_dest, ms_final_result, ms_pc  instruction presented to WB
//   ms_fwd_valid, ms_fwd_blk,
//   ms_rf_dest, ms_rf_data           forward / block bus toward ID
//   ms_discard_busy                  stale responses outstanding; EX must not issue
`timescale 1ns/1ps
module mem_stage_vlat #(
  parameter int DISCARD_WD     = 2,
  parameter bit FWD_LOAD_EARLY = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ms_flush,
  input  logic        ws_allowin,
  output logic        ms_allowin,
  input  logic        es_to_ms_valid,
  input  logic [2:0]  es_ld_op,
  input  logic        es_res_from_mem,
  input  logic        es_mem_req,
  input  logic        es_gr_we,
  input  logic [4:0]  es_dest,
  input  logic [31:0] es_exe_result,
  input  logic [31:0] es_pc,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  output logic        ms_to_ws_valid,
  output logic [3:0]  ms_gr_strb,
  output logic [4:0]  ms_dest,
  output logic [31:0] ms_final_result,
  output logic [31:0] ms_pc,
  output logic [3:0]  ms_fwd_valid,
  output logic        ms_fwd_blk,
  output logic [4:0]  ms_rf_dest,
  output logic [31:0] ms_rf_data,
  output logic        ms_discard_busy
);

  localparam logic [2:0] LD_LB  = 3'd0;
  localparam logic [2:0] LD_LBU = 3'd1;
  localparam logic [2:0] LD_LH  = 3'd2;
  localparam logic [2:0] LD_LHU = 3'd3;
  localparam logic [2:0] LD_LW  = 3'd4;
  localparam logic [2:0] LD_LWL = 3'd5;
  localparam logic [2:0] LD_LWR = 3'd6;

  localparam logic [DISCARD_WD-1:0] DISCARD_MAX = '1;
  // Two spare bits so cnt + 2 never wraps before saturation.
  localparam int CW = DISCARD_WD + 2;

  // Stage state
  logic                  ms_valid;
  logic                  buf_vld;
  logic [31:0]           buf_data;
  logic [DISCARD_WD-1:0] discard_cnt;

  // Latched EX fields
  logic [2:0]            ld_op;
  logic                  res_from_mem;
  logic                  mem_req;
  logic                  gr_we;
  logic [4:0]            dest;
  logic [31:0]           exe_result;
  logic [31:0]           pc;

  // Control terms
  logic                  rsp_live;
  logic                  ms_ready_go;
  logic                  leaving;
  logic                  accept;
  logic                  buf_fill;
  logic                  inc_ms;
  logic                  inc_es;
  logic                  dec;
  logic [CW-1:0]         cnt_sum;
  logic [DISCARD_WD-1:0] cnt_nxt;

  // Data path
  logic [31:0]           ms_data;
  logic [15:0]           ld_half;
  logic [7:0]            ld_byte;
  logic [31:0]           load_result;
  logic [3:0]            lwlr_strb;
  logic                  is_lwlr;

  // A response is only meaningful once every stale response has drained.
  assign rsp_live    = data_sram_data_ok & (discard_cnt == '0);
  assign ms_data     = buf_vld ? buf_data : data_sram_rdata;
  assign ms_ready_go = ~mem_req | buf_vld | rsp_live;
  assign leaving     = ms_valid & ms_ready_go & ws_allowin;
  assign ms_allowin  = ~ms_valid | (ms_ready_go & ws_allowin);
  assign accept      = ms_allowin & es_to_ms_valid & ~ms_flush;

  // Park the response only when the instruction cannot hand it to WB now.
  assign buf_fill    = rsp_live & ms_valid & mem_req & ~buf_vld & ~leaving;

  // Outstanding requests orphaned by a flush: the held instruction still
  // waiting on its data, plus a request EX launched in the flush cycle.
  assign inc_ms      = ms_valid & mem_req & ~buf_vld & ~rsp_live;
  assign inc_es      = es_to_ms_valid & es_mem_req;
  assign dec         = data_sram_data_ok & (discard_cnt != '0);

  always_comb begin
    cnt_sum = CW'(discard_cnt);
    if (ms_flush) begin
      cnt_sum = cnt_sum + CW'(inc_ms) + CW'(inc_es);
    end
    cnt_sum = cnt_sum - CW'(dec);
    if (cnt_sum > CW'(DISCARD_MAX)) begin
      cnt_nxt = DISCARD_MAX;
    end else begin
      cnt_nxt = cnt_sum[DISCARD_WD-1:0];
    end
  end

  // Control state: valid, response buffer, discard counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ms_valid    <= 1'b0;
      buf_vld     <= 1'b0;
      buf_data    <= 32'h0;
      discard_cnt <= '0;
    end else begin
      if (ms_flush) begin
        ms_valid <= 1'b0;
        buf_vld  <= 1'b0;
      end else if (ms_allowin) begin
        ms_valid <= es_to_ms_valid;
        buf_vld  <= 1'b0;
      end else if (buf_fill) begin
        buf_vld  <= 1'b1;
        buf_data <= data_sram_rdata;
      end
      discard_cnt <= cnt_nxt;
    end
  end

  // Instruction fields, captured only on a real accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_op        <= 3'd0;
      res_from_mem <= 1'b0;
      mem_req      <= 1'b0;
      gr_we        <= 1'b0;
      dest         <= 5'd0;
      exe_result   <= 32'h0;
      pc           <= 32'h0;
    end else if (accept) begin
      ld_op        <= es_ld_op;
      res_from_mem <= es_res_from_mem;
      mem_req      <= es_mem_req;
      gr_we        <= es_gr_we;
      dest         <= es_dest;
      exe_result   <= es_exe_result;
      pc           <= es_pc;
    end
  end

  // Load extraction
  always_comb begin
    ld_half     = exe_result[1] ? ms_data[31:16] : ms_data[15:0];
    ld_byte     = exe_result[0] ? ld_half[15:8] : ld_half[7:0];
    load_result = ms_data;
    lwlr_strb   = 4'b1111;
    is_lwlr     = 1'b0;
    case (ld_op)
      LD_LB:  load_result = {{24{ld_byte[7]}}, ld_byte};
      LD_LBU: load_result = {24'h0, ld_byte};
      LD_LH:  load_result = {{16{ld_half[15]}}, ld_half};
      LD_LHU: load_result = {16'h0, ld_half};
      LD_LW:  load_result = ms_data;
      LD_LWL: begin
        // Low bytes of the word merge into the high end of the register.
        is_lwlr = 1'b1;
        case (exe_result[1:0])
          2'd0: begin load_result = {ms_data[7:0], 24'h0};  lwlr_strb = 4'b1000; end
          2'd1: begin load_result = {ms_data[15:0], 16'h0}; lwlr_strb = 4'b1100; end
          2'd2: begin load_result = {ms_data[23:0], 8'h0};  lwlr_strb = 4'b1110; end
          default: begin load_result = ms_data;             lwlr_strb = 4'b1111; end
        endcase
      end
      LD_LWR: begin
        // High bytes of the word merge into the low end of the register.
        is_lwlr = 1'b1;
        case (exe_result[1:0])
          2'd0: begin load_result = ms_data;                 lwlr_strb = 4'b1111; end
          2'd1: begin load_result = {8'h0, ms_data[31:8]};   lwlr_strb = 4'b0111; end
          2'd2: begin load_result = {16'h0, ms_data[31:16]}; lwlr_strb = 4'b0011; end
          default: begin load_result = {24'h0, ms_data[31:24]}; lwlr_strb = 4'b0001; end
        endcase
      end
      default: load_result = ms_data;
    endcase
  end

  // WB outputs
  assign ms_to_ws_valid  = ms_valid & ms_ready_go & ~ms_flush;
  assign ms_final_result = res_from_mem ? load_result : exe_result;
  assign ms_gr_strb      = ~gr_we ? 4'b0000 : (is_lwlr ? lwlr_strb : 4'b1111);
  assign ms_dest         = dest;
  assign ms_pc           = pc;

  // Forward / block bus.  With FWD_LOAD_EARLY the live response is
  // forwarded in its arrival cycle; otherwise ID waits for the buffer.
  assign ms_fwd_valid    = {4{ms_valid}} & ms_gr_strb;
  assign ms_fwd_blk      = ms_valid & res_from_mem
                         & ~(buf_vld | (FWD_LOAD_EARLY & rsp_live));
  assign ms_rf_dest      = dest;
  assign ms_rf_data      = ms_final_result;
  assign ms_discard_busy = (discard_cnt != '0);

endmodule
